// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types for the synctimer drift controller: FSM states, time and error words.
package jellyvl_synctimer_pkg;

    localparam int DEF_TIMER_WIDTH = 64;
    localparam int DEF_ERROR_WIDTH = 32;

    typedef logic        [DEF_TIMER_WIDTH-1:0] t_time;
    typedef logic signed [DEF_ERROR_WIDTH-1:0] t_error;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_DECIDE = 3'd2,
        ST_SET    = 3'd3,
        ST_ADJUST = 3'd4,
        ST_GAP    = 3'd5
    } t_state;

endpackage

// File: rtl/jellyvl_synctimer_adjust_ctl_if.sv
// Bus between the sync-packet receiver / timer block (master) and the drift controller (slave).
interface jellyvl_synctimer_adjust_ctl_if #(
    parameter int TIMER_WIDTH = 64
);
    // Every channel is valid/ready: a transfer happens on a clock edge where both are high;
    // once valid is raised its payload stays stable and valid stays high until that transfer.
    // set_valid is a one-cycle command with no ready.
    logic [TIMER_WIDTH-1:0] sample_master_time;
    logic [TIMER_WIDTH-1:0] sample_local_time;
    logic                   sample_valid;
    logic                   sample_ready;

    logic [TIMER_WIDTH-1:0] set_time;
    logic                   set_valid;

    logic                   adjust_sign;
    logic                   adjust_valid;
    logic                   adjust_ready;

    modport master (
        output sample_master_time, sample_local_time, sample_valid,
        input  sample_ready,
        input  set_time, set_valid,
        input  adjust_sign, adjust_valid,
        output adjust_ready
    );

    modport slave (
        input  sample_master_time, sample_local_time, sample_valid,
        output sample_ready,
        output set_time, set_valid,
        output adjust_sign, adjust_valid,
        input  adjust_ready
    );

endinterface

// File: rtl/jellyvl_synctimer_error_sat.sv
// Combinational master-minus-local difference, saturated into the signed error range.
module jellyvl_synctimer_error_sat #(
    parameter int TIMER_WIDTH = 64,
    parameter int ERROR_WIDTH = 32
) (
    input  logic [TIMER_WIDTH-1:0]        master_i,
    input  logic [TIMER_WIDTH-1:0]        local_i,
    output logic signed [ERROR_WIDTH-1:0] error_o
);

    localparam logic [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MIN = {1'b1, {(ERROR_WIDTH-1){1'b0}}};

    logic [TIMER_WIDTH-1:0]           diff;
    logic [TIMER_WIDTH-ERROR_WIDTH:0] upper;

    // The difference fits when every bit above the error sign bit matches it.
    always_comb begin
        diff  = master_i - local_i;
        upper = diff[TIMER_WIDTH-1:ERROR_WIDTH-1];
        if (upper == '0 || upper == '1) begin
            error_o = diff[ERROR_WIDTH-1:0];
        end else if (diff[TIMER_WIDTH-1]) begin
            error_o = ERR_MIN;
        end else begin
            error_o = ERR_MAX;
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_adjust_ctl.sv
// Synctimer drift controller: steps the timer on large offsets, trickles +-1 adjusts otherwise.
// Build option: define JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN to enable the timer step (SET) path.
module jellyvl_synctimer_adjust_ctl
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH     = DEF_TIMER_WIDTH,
    parameter int ERROR_WIDTH     = DEF_ERROR_WIDTH,
    parameter int SET_THRESHOLD   = 1000,
    parameter int MAX_ADJUST      = 255,
    parameter int ADJUST_INTERVAL = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [TIMER_WIDTH-1:0]        current_time,
    jellyvl_synctimer_adjust_ctl_if.slave bus,
    output logic                          busy,
    output logic signed [ERROR_WIDTH-1:0] last_error,
    output t_state                        dbg_state
);

    localparam int RW = $clog2(MAX_ADJUST + 1);
    localparam int GW = (ADJUST_INTERVAL > 1) ? $clog2(ADJUST_INTERVAL) : 1;

    localparam logic [ERROR_WIDTH-1:0] ERR_MAX   = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0] ERR_MIN   = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
    localparam logic [ERROR_WIDTH-1:0] ADJ_MAX_E = ERROR_WIDTH'(MAX_ADJUST);
    localparam logic [RW-1:0]          ADJ_MAX_R = RW'(MAX_ADJUST);
    localparam logic [GW-1:0]          GAP_LOAD  = GW'(ADJUST_INTERVAL - 1);

    t_state                        state_q, state_d;
    logic [TIMER_WIDTH-1:0]        master_q, master_d;
    logic [TIMER_WIDTH-1:0]        local_q, local_d;
    logic signed [ERROR_WIDTH-1:0] err_q, err_d;
    logic                          sign_q, sign_d;
    logic [RW-1:0]                 remaining_q, remaining_d;
    logic [GW-1:0]                 gap_q, gap_d;

    logic signed [ERROR_WIDTH-1:0] sat_err;
    logic [ERROR_WIDTH-1:0]        abs_err;
    logic [RW-1:0]                 adj_count;

    logic                          sample_ready_w;
    logic                          sample_fire;
    logic                          busy_w;
    logic                          adjust_valid_w;
    logic                          set_valid_w;

`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
    localparam logic [ERROR_WIDTH-1:0] THR_E = ERROR_WIDTH'(SET_THRESHOLD);
    logic [TIMER_WIDTH-1:0] set_time_q, set_time_d;
`else
    logic unused_current_time;
    assign unused_current_time = ^current_time;
`endif

    jellyvl_synctimer_error_sat #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .ERROR_WIDTH (ERROR_WIDTH)
    ) u_error_sat (
        .master_i (master_q),
        .local_i  (local_q),
        .error_o  (sat_err)
    );

    // Magnitude of the most-negative error clamps to the largest positive value.
    always_comb begin
        if (!err_q[ERROR_WIDTH-1]) begin
            abs_err = err_q;
        end else if (err_q == ERR_MIN) begin
            abs_err = ERR_MAX;
        end else begin
            abs_err = -err_q;
        end
        adj_count = (abs_err > ADJ_MAX_E) ? ADJ_MAX_R : abs_err[RW-1:0];
    end

    assign sample_fire = bus.sample_valid && sample_ready_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            master_q    <= '0;
            local_q     <= '0;
            err_q       <= '0;
            sign_q      <= 1'b0;
            remaining_q <= '0;
            gap_q       <= '0;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
            set_time_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            master_q    <= master_d;
            local_q     <= local_d;
            err_q       <= err_d;
            sign_q      <= sign_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
            set_time_q  <= set_time_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        master_d    = master_q;
        local_d     = local_q;
        err_d       = err_q;
        sign_d      = sign_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
        set_time_d  = set_time_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sample_fire) begin
                    master_d = bus.sample_master_time;
                    local_d  = bus.sample_local_time;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                err_d   = sat_err;
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (err_q == '0) begin
                    state_d = ST_IDLE;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
                end else if (abs_err > THR_E) begin
                    set_time_d = current_time + TIMER_WIDTH'(err_q);
                    state_d    = ST_SET;
`endif
                end else begin
                    remaining_d = adj_count;
                    sign_d      = err_q[ERROR_WIDTH-1];
                    state_d     = ST_ADJUST;
                end
            end
            ST_SET: begin
                state_d = ST_IDLE;
            end
            // A raised adjust_valid only leaves ADJUST through a handshake, so enable is checked there.
            ST_ADJUST: begin
                if (bus.adjust_ready) begin
                    remaining_d = remaining_q - RW'(1);
                    if (remaining_q == RW'(1) || !enable) begin
                        state_d = ST_IDLE;
                    end else if (ADJUST_INTERVAL == 1) begin
                        state_d = ST_ADJUST;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GW'(1);
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (gap_q == GW'(1)) begin
                    state_d = ST_ADJUST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so adjust_valid never sees adjust_ready.
    always_comb begin
        sample_ready_w = enable && !reset && (state_q == ST_IDLE);
        busy_w         = (state_q != ST_IDLE);
        adjust_valid_w = (state_q == ST_ADJUST);
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
        set_valid_w    = (state_q == ST_SET);
`else
        set_valid_w    = 1'b0;
`endif
    end

    assign bus.sample_ready = sample_ready_w;
    assign bus.adjust_valid = adjust_valid_w;
    assign bus.adjust_sign  = sign_q;
    assign bus.set_valid    = set_valid_w;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
    assign bus.set_time     = set_time_q;
`else
    assign bus.set_time     = '0;
`endif
    assign busy       = busy_w;
    assign last_error = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jellyvl_synctimer_adjust_ctl.sv
// Bench for jellyvl_synctimer_adjust_ctl: directed samples, expected-queue scoreboard, negedge monitor.
module tb_jellyvl_synctimer_adjust_ctl;
    import jellyvl_synctimer_pkg::*;

    localparam int TW       = 64;
    localparam int EW       = 32;
    localparam int INTERVAL = 16;
`ifdef JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN
    localparam bit SET_EN = 1'b1;
`else
    localparam bit SET_EN = 1'b0;
`endif
    localparam t_time CT = 64'h0000_1234_5678_0000;

    // ---------------- clock / reset ----------------
    logic    clk = 1'b0;
    logic    reset = 1'b1;
    logic    enable = 1'b0;
    t_time   current_time;
    logic    busy;
    logic [EW-1:0] last_error;
    t_state  dbg_state;
    int      cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jellyvl_synctimer_adjust_ctl_if #(.TIMER_WIDTH(TW)) bus ();

    jellyvl_synctimer_adjust_ctl #(
        .TIMER_WIDTH     (TW),
        .ERROR_WIDTH     (EW),
        .SET_THRESHOLD   (1000),
        .MAX_ADJUST      (255),
        .ADJUST_INTERVAL (INTERVAL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .current_time (current_time),
        .bus          (bus),
        .busy         (busy),
        .last_error   (last_error),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_err_q[$];
    logic [0:0]    exp_sign_q[$];
    logic [TW-1:0] exp_set_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic expect_adj(input logic [EW-1:0] err, input int n, input logic sgn);
        exp_err_q.push_back(err);
        for (int i = 0; i < n; i++) exp_sign_q.push_back(sgn);
    endtask

    task automatic expect_big(input logic [EW-1:0] err, input logic sgn, input logic [TW-1:0] st);
        exp_err_q.push_back(err);
        if (SET_EN) exp_set_q.push_back(st);
        else for (int i = 0; i < 255; i++) exp_sign_q.push_back(sgn);
    endtask

    // ---------------- monitor ----------------
    int acc_cyc = 0;
    int last_hs = 0;
    bit err_pend = 1'b0;
    bit first_pend = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_sign = 1'b0;
    bit prev_hs = 1'b0;
    bit prev_reset = 1'b1;

    always @(negedge clk) begin
        if (err_pend && cyc == acc_cyc + 2) begin
            err_pend = 1'b0;
            if (exp_err_q.size() == 0) fail_now("last_error", "no expected error queued");
            else check("last_error", last_error, exp_err_q.pop_front());
        end
        if (bus.adjust_valid === 1'b1 && !prev_valid) begin
            if (first_pend) begin
                check("adj_first_latency", cyc - acc_cyc, 3);
                first_pend = 1'b0;
            end else begin
                check("adj_spacing", cyc - last_hs, INTERVAL);
            end
        end
        if (bus.adjust_valid === 1'b1 && prev_valid && !prev_hs)
            check("adj_sign_hold", bus.adjust_sign, prev_sign);
        if (prev_valid && !prev_hs && !prev_reset)
            check("adj_no_withdraw", bus.adjust_valid, 1);
        if (bus.adjust_valid === 1'b1 && bus.adjust_ready === 1'b1) begin
            if (exp_sign_q.size() == 0) fail_now("adj_unexpected", "adjust handshake with none expected");
            else check("adj_sign", bus.adjust_sign, exp_sign_q.pop_front());
            last_hs = cyc;
        end
        if (bus.set_valid === 1'b1) begin
            if (exp_set_q.size() == 0) fail_now("set_unexpected", "set_valid with none expected");
            else check("set_time", bus.set_time, exp_set_q.pop_front());
        end
        if (bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
            check("accept_only_idle", busy, 0);
            acc_cyc    = cyc;
            err_pend   = 1'b1;
            first_pend = 1'b1;
        end
        prev_valid = (bus.adjust_valid === 1'b1);
        prev_sign  = bus.adjust_sign;
        prev_hs    = (bus.adjust_valid === 1'b1 && bus.adjust_ready === 1'b1);
        prev_reset = reset;
    end

    // ---------------- driver tasks ----------------
    task automatic send_sample(input logic [TW-1:0] m, input logic [TW-1:0] l);
        int n = 0;
        @(posedge clk); #1;
        bus.sample_master_time = m;
        bus.sample_local_time  = l;
        bus.sample_valid       = 1'b1;
        @(negedge clk);
        while (bus.sample_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (bus.sample_ready !== 1'b1) fail_now("sample_accept", "sample never accepted");
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic drain_check(input string name);
        check(name, exp_err_q.size() + exp_sign_q.size() + exp_set_q.size(), 0);
    endtask

    task automatic wait_adjust_valid();
        int n = 0;
        while (bus.adjust_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("adj_raised", bus.adjust_valid, 1);
    endtask

    task automatic check_reset_values();
        check("rst_sample_ready", bus.sample_ready, 0);
        check("rst_set_valid", bus.set_valid, 0);
        check("rst_set_time", bus.set_time, 0);
        check("rst_adjust_valid", bus.adjust_valid, 0);
        check("rst_adjust_sign", bus.adjust_sign, 0);
        check("rst_busy", busy, 0);
        check("rst_last_error", last_error, 0);
        check("rst_state", dbg_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.sample_valid       = 1'b0;
        bus.sample_master_time = '0;
        bus.sample_local_time  = '0;
        bus.adjust_ready       = 1'b1;
        current_time           = CT;
        enable                 = 1'b1;
        reset                  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", bus.sample_ready, 1);

        // small positive and negative offsets
        expect_adj(32'd10, 10, 1'b0);
        send_sample(64'd1000, 64'd990);
        wait_idle(400);
        drain_check("drain_pos10");

        expect_adj(32'hFFFF_FFEC, 20, 1'b1);
        send_sample(64'd500, 64'd520);
        wait_idle(600);
        drain_check("drain_neg20");

        // large offset: step or clamped trickle
        expect_big(32'd5000, 1'b0, CT + 64'd5000);
        send_sample(64'd105000, 64'd100000);
        wait_idle(5000);
        drain_check("drain_pos5000");

        expect_adj(32'd0, 0, 1'b0);
        send_sample(64'd777, 64'd777);
        wait_idle(10);
        drain_check("drain_zero");

        // threshold boundary: -1000 trickles, -1001 steps
        expect_adj(32'hFFFF_FC18, 255, 1'b1);
        send_sample(64'd0, 64'd1000);
        wait_idle(5000);
        drain_check("drain_neg1000");

        expect_big(32'hFFFF_FC17, 1'b1, CT - 64'd1001);
        send_sample(64'd0, 64'd1001);
        wait_idle(5000);
        drain_check("drain_neg1001");

        // adjust_ready held low for 40 cycles
        bus.adjust_ready = 1'b0;
        expect_adj(32'd3, 3, 1'b0);
        send_sample(64'd50, 64'd47);
        wait_adjust_valid();
        repeat (40) @(negedge clk);
        check("hold_valid_after_40", bus.adjust_valid, 1);
        check("hold_busy_after_40", busy, 1);
        @(posedge clk); #1;
        bus.adjust_ready = 1'b1;
        wait_idle(200);
        drain_check("drain_hold");

        // enable dropped during GAP
        begin
            int n = 0;
            expect_adj(32'hFFFF_FFFB, 1, 1'b1);
            send_sample(64'd10, 64'd15);
            while (!(bus.adjust_valid === 1'b1 && bus.adjust_ready === 1'b1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk); #1;
            enable = 1'b0;
            repeat (40) @(negedge clk);
            check("disable_busy", busy, 0);
            check("disable_adjust_valid", bus.adjust_valid, 0);
            check("disable_sample_ready", bus.sample_ready, 0);
            drain_check("drain_disable");
            enable = 1'b1;
        end

        // positive saturation, with a second sample held off until idle
        expect_big(32'h7FFF_FFFF, 1'b0, CT + 64'h0000_0000_7FFF_FFFF);
        expect_adj(32'hFFFF_FFFE, 2, 1'b1);
        send_sample(64'h0000_0100_0000_0007, 64'd7);
        send_sample(64'd1, 64'd3);
        wait_idle(200);
        drain_check("drain_sat_pos");

        // negative saturation
        expect_big(32'h8000_0000, 1'b1, CT - 64'h0000_0000_8000_0000);
        send_sample(64'd0, 64'h0000_0100_0000_0000);
        wait_idle(5000);
        drain_check("drain_sat_neg");

        // reset while adjust_valid is high
        bus.adjust_ready = 1'b0;
        expect_adj(32'hFFFF_FFFC, 0, 1'b1);
        send_sample(64'd0, 64'd4);
        wait_adjust_valid();
        check("pre_reset_sign", bus.adjust_sign, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.adjust_ready = 1'b1;
        repeat (5) @(negedge clk);
        drain_check("drain_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jellyvl_synctimer_adjust_ctl.md
# jellyvl_synctimer_adjust_ctl

Closed-loop drift controller for the synctimer counter. It accepts paired (master, local) timestamp samples and computes the signed offset. Depending on offset size, it either steps the timer with one `set` pulse or trickles ±1 rate-adjust requests through the timer's `adjust_*` handshake at a fixed spacing. It sits between the sync-packet receiver and the timer block.

## Interface
Parameters:
- `TIMER_WIDTH`, 64: timer width.
- `ERROR_WIDTH`, 32: signed offset width; the difference saturates to this range.
- `SET_THRESHOLD`, 1000: step the timer when |error| > this value.
- `MAX_ADJUST`, 255: maximum ±1 pulses issued per sample.
- `ADJUST_INTERVAL`, 16: minimum cycles between accepted adjust pulses (≥1).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: controller enable.
- `sample_master_time`  in  TIMER_WIDTH: master time at the capture instant.
- `sample_local_time`  in  TIMER_WIDTH: local time at the same instant.
- `sample_valid`  in  1 / `sample_ready`  out  1: sample handshake.
- `current_time`  in  TIMER_WIDTH: live timer output.
- `set_time`  out  TIMER_WIDTH / `set_valid`  out  1: step command to the timer.
- `adjust_sign`  out  1 / `adjust_valid`  out  1 / `adjust_ready`  in  1: rate-adjust handshake. Sign 0 = speed up, sign 1 = slow down.
- `busy`  out  1: high outside IDLE.
- `last_error`  out  ERROR_WIDTH: signed offset of the last accepted sample.

## Operation
- States: IDLE, CALC, DECIDE, SET, ADJUST, GAP.
- IDLE: `sample_ready = enable`. On accept, register both times and go to CALC.
- CALC: compute `diff = master - local` at TIMER_WIDTH, two's complement. Saturate `diff` to the signed ERROR_WIDTH range and store it in `last_error`. Go to DECIDE.
- DECIDE:
  - error == 0: go to IDLE.
  - |error| > SET_THRESHOLD (and the SET feature is compiled in): go to SET.
  - Otherwise: `remaining = min(|error|, MAX_ADJUST)`, `adjust_sign = error < 0`, go to ADJUST.
  - The magnitude of the most-negative value saturates to the max positive value.
- SET: one-cycle `set_valid`, with `set_time = current_time + sign_extend(error)` (registered in the same cycle). Then go to IDLE.
- ADJUST: `adjust_valid = 1` with sign held stable until `adjust_ready`.
  - On a handshake, decrement `remaining`.
  - If `remaining` reaches 0, or `enable` is low, go to IDLE.
  - Otherwise, load the gap counter with ADJUST_INTERVAL-1 and go to GAP. If ADJUST_INTERVAL = 1, stay in ADJUST.
- GAP: count down to 0, then go to ADJUST. If `enable` is low, go to IDLE.
- `adjust_valid` never depends combinationally on `adjust_ready`. The timer's ready is itself a function of valid, so the loop must not close.
- Once raised, `adjust_valid` is never withdrawn before its handshake, even if `enable` falls.
- Samples arriving while busy are back-pressured (`sample_ready = 0`), never dropped.

## Timing
- Reset values: `sample_ready=0`, `set_valid=0`, `set_time=0`, `adjust_valid=0`, `adjust_sign=0`, `busy=0`, `last_error=0`, state IDLE. `sample_ready` may rise in the first cycle after reset deassert.
- Sample accept at cycle T: `last_error` valid at T+2. `set_valid` pulses at T+3. `adjust_valid` first rises at T+3.
- Adjust pulses: the next `adjust_valid` rises exactly ADJUST_INTERVAL cycles after the previous handshake cycle.
- `adjust_ready` may stay low for any number of cycles; outputs hold unchanged.
- Reset asserted mid-ADJUST drops `adjust_valid` the next cycle. This is the only allowed withdrawal.
- Saturation: diff ≥ 2^(ERROR_WIDTH-1) gives the max positive value; diff < −2^(ERROR_WIDTH-1) gives the min negative value.

## Configuration
- `JELLYVL_SYNCTIMER_ADJUST_CTL_SET_EN`
  - Defined: the SET path is active as described.
  - Undefined: SET state and `set_time` logic are removed, `set_valid` is tied 0 and `set_time` to 0. Every nonzero error goes to ADJUST, clamped by MAX_ADJUST.

## Structure
- Shared package `jellyvl_synctimer_pkg`: the state enum, the `t_time` typedef (TIMER_WIDTH), and the signed `t_error` typedef.
- Sub-module `jellyvl_synctimer_error_sat`: combinational subtract plus saturate, with the `last_error` register in the parent.

## Test plan
- master=1000, local=990, THRESHOLD=1000, INTERVAL=16 → `last_error=10`; exactly 10 pulses with `adjust_sign=0`, spaced 16 cycles apart.
- master=500, local=520 → `last_error=−20`; 20 pulses with sign 1.
- master=local+5000, SET_EN defined → a single `set_valid` with `set_time = current_time+5000`, and no adjust pulses. SET_EN undefined → 255 sign-0 pulses.
- Hold `adjust_ready` low for 40 cycles → valid and sign stay stable throughout; exactly one decrement on release.
- Drop `enable` mid-GAP → return to IDLE with no further valid. Assert reset while `adjust_valid` is high → all outputs reach reset values the next cycle.
- master−local = 2^40 with ERROR_WIDTH=32 → `last_error = 0x7FFFFFFF`. A sample offered while busy is held off until IDLE.
